uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 4, number of requesters, 2..8.
- WDOG_CYCLES, 32, watchdog limit in clk_uart cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk_uart, in, 1, single clock; all logic rising-edge.
- clrn, in, 1, reset; synchronous, active-low.
- req, in, NREQ, per-channel byte request.
- req_data, in, 8*NREQ, channel i byte at [8i+7:8i].
- ack, out, NREQ, one-cycle pulse when channel's byte is written.
- grant_id, out, $clog2(NREQ), channel currently owning the transmitter.
- busy, out, 1, high in any state other than IDLE.
- wrn, out, 1, active-low write strobe to the transmitter.
- d_in, out, 8, byte to the transmitter.
- t_empty, in, 1, transmitter empty.
- sending, in, 1, transmitter frame in progress.
- frames_sent, out, 16, completed-frame counter.
- wdog_err, out, 1, sticky watchdog error.

Function
REQ-003 The FSM SHALL have the states IDLE, WRITE, WAIT_START and WAIT_DONE.
REQ-004 IDLE SHALL move to WRITE when t_empty=1, sending=0 and req is nonzero.
- On that edge it SHALL latch the winner into grant_id and its byte into d_in.
REQ-005 Arbitration SHALL be round-robin.
- Search starts at (last_grant+1) mod NREQ.
- last_grant resets to NREQ-1, so channel 0 wins first.
REQ-006 In WRITE, wrn SHALL be 0 and ack[grant_id] SHALL be 1 for exactly one cycle.
- The next state SHALL be WAIT_START.
REQ-007 Latency: with req asserted in IDLE at edge N, wrn SHALL be low in the cycle following edge N.
REQ-008 WAIT_START SHALL move to WAIT_DONE on sending=1.
REQ-009 WAIT_DONE SHALL move to IDLE on sending=0.
- On the same edge, frames_sent SHALL increment and last_grant SHALL take grant_id.
REQ-010 wrn SHALL be registered and SHALL be 1 in every state except WRITE.
REQ-011 d_in and grant_id SHALL hold stable from WRITE through WAIT_DONE.
REQ-012 Deasserting req after the grant SHALL have no effect on the frame in flight.
REQ-013 A requester holding req after its ack SHALL be re-eligible only under round-robin order.
REQ-014 frames_sent SHALL wrap from 0xFFFF to 0x0000.
REQ-015 Requests arriving in any non-IDLE state SHALL be ignored until IDLE.
REQ-016 ack SHALL be one-hot or zero.

Reset
REQ-017 While clrn=0 at a clock edge, the block SHALL reset to:
- state IDLE
- wrn=1, d_in=0, grant_id=0, ack=0, busy=0
- frames_sent=0, wdog_err=0
- last_grant=NREQ-1
- watchdog counter=0
REQ-018 Reset mid-frame SHALL abandon the frame, raise no ack and leave frames_sent=0.

Configuration
REQ-019 With UART_ARB_WDOG_EN defined, a counter SHALL run in WAIT_START and WAIT_DONE.
- It SHALL clear on entry to WAIT_START.
- On reaching WDOG_CYCLES it SHALL force IDLE, set wdog_err (cleared only by reset) and skip the frames_sent increment.
- last_grant SHALL still update.
REQ-020 Without UART_ARB_WDOG_EN, there SHALL be no counter and wdog_err SHALL be constant 0.
- WAIT_START and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-021 Package uart_pkg SHALL hold:
- the FSM state enum (2-bit)
- default NREQ
- default WDOG_CYCLES
REQ-022 Round-robin selection SHALL be in sub-module uart_rr_arbiter.
- Inputs: req and last_grant.
- Outputs: winner index and a valid flag; no state.

Verification
REQ-023 Single request: req=4'b0001, req_data[7:0]=8'hA5, TX model asserts sending 2 cycles after wrn and holds it 12 cycles.
- Required: wrn low for exactly 1 cycle, d_in=8'hA5, ack=4'b0001, frames_sent=1.
REQ-024 All request: req=4'b1111 held for 4 frames.
- Required: ack order is channels 0,1,2,3 and frames_sent=4.
REQ-025 Late request: req=4'b0100 raised during WAIT_DONE of a channel-1 frame.
- Required: no ack until IDLE, then channel 2 granted.
REQ-026 Watchdog: UART_ARB_WDOG_EN defined, sending held 0 after the write.
- Required: IDLE after 32 cycles, wdog_err=1, frames_sent unchanged.
- Without the macro: the FSM stays in WAIT_START.
REQ-027 Reset and wrap:
- clrn=0 for 1 cycle during WAIT_DONE: all outputs at reset values on the next cycle and wrn=1.
- frames_sent preset to 0xFFFF, one frame sent: reads 0x0000.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg -- shared state encoding and defaults for the UART TX arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_WDOG_CYCLES = 32;

endpackage

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
// ============================================================================
// uart_rr_arbiter -- stateless round-robin pick, searching from last_grant+1.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int GW = $clog2(NREQ);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (req[GW'(idx)]) begin
        winner = GW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter -- shares one UART transmitter among NREQ byte requesters.
// Rev 1.0 -- optional watchdog enabled by defining UART_ARB_WDOG_EN.
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                    clk_uart,
  input  logic                    clrn,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    wrn,
  output logic [7:0]              d_in,
  input  logic                    t_empty,
  input  logic                    sending,
  output logic [15:0]             frames_sent,
  output logic                    wdog_err
);

  localparam int GW = $clog2(NREQ);

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          win_valid;
  logic          wdog_fire;

  uart_rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req       (req),
    .last_grant(last_grant),
    .winner    (winner),
    .valid     (win_valid)
  );

`ifdef UART_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_err_q;
  logic          in_wait;

  assign in_wait   = (state == ST_WAIT_START) || (state == ST_WAIT_DONE);
  assign wdog_fire = in_wait && (wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_err_q;

  // Counter is zero whenever not waiting, so entry to WAIT_START always starts from 0.
  always_ff @(posedge clk_uart) begin
    if (!clrn) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (wdog_fire) begin
        wdog_err_q <= 1'b1;
      end
      if (in_wait && !wdog_fire) begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end else begin
        wdog_cnt <= '0;
      end
    end
  end
`else
  logic unused_wdog_cfg;

  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_fire       = 1'b0;
  assign wdog_err        = 1'b0;
`endif

  always_ff @(posedge clk_uart) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      wrn         <= 1'b1;
      d_in        <= 8'h00;
      grant_id    <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      frames_sent <= 16'h0000;
      last_grant  <= GW'(NREQ - 1);
    end else begin
      ack <= '0;
      wrn <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (t_empty && !sending && win_valid) begin
            state    <= ST_WRITE;
            grant_id <= winner;
            d_in     <= req_data[{winner, 3'b000} +: 8];
            ack      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            wrn      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (wdog_fire) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
          end else if (sending) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // A watchdog timeout abandons the frame: it is not counted as sent.
          if (wdog_fire) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
          end else if (!sending) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            last_grant  <= grant_id;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter -- self-checking bench with a frame-level reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int WDOG = 32;
`ifdef UART_ARB_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic              clk_uart = 1'b0;
  logic              clrn     = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic [1:0]        grant_id;
  logic              busy;
  logic              wrn;
  logic [7:0]        d_in;
  logic              t_empty  = 1'b1;
  logic              sending  = 1'b0;
  logic [15:0]       frames_sent;
  logic              wdog_err;

  logic tx_auto       = 1'b1;
  logic preset_frames = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter #(
    .NREQ       (NREQ),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_uart   (clk_uart),
    .clrn       (clrn),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .wrn        (wrn),
    .d_in       (d_in),
    .t_empty    (t_empty),
    .sending    (sending),
    .frames_sent(frames_sent),
    .wdog_err   (wdog_err)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  bit          m_active  = 1'b0;  // a frame owns the transmitter
  bit          m_write   = 1'b0;  // this cycle is the single write-strobe cycle
  bit          m_started = 1'b0;  // transmitter has reported sending for this frame
  int          m_age     = 0;     // cycles spent waiting on the transmitter
  int          m_last    = NREQ - 1;
  int          m_grant   = 0;
  logic [7:0]  m_data    = 8'h00;
  logic [15:0] m_frames  = 16'h0000;
  bit          m_err     = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk_uart) begin
    if (!clrn) begin
      m_active = 0; m_write = 0; m_started = 0; m_age = 0;
      m_grant = 0; m_data = 8'h00; m_frames = 16'h0000; m_err = 0; m_last = NREQ - 1;
    end else begin
      if (preset_frames) m_frames = 16'hFFFF;
      if (m_write) begin
        m_write = 0; m_started = 0; m_age = 0;
      end else if (m_active) begin
        if (WDOG_ON && m_age == WDOG - 1) begin
          m_active = 0; m_err = 1; m_last = m_grant;
        end else begin
          m_age++;
          if (!m_started) begin
            if (sending) m_started = 1;
          end else if (!sending) begin
            m_active = 0; m_frames = m_frames + 16'd1; m_last = m_grant;
          end
        end
      end else if (t_empty && !sending && req != '0) begin
        m_grant  = rr_pick(req, m_last);
        m_data   = req_data[8*m_grant +: 8];
        m_write  = 1;
        m_active = 1;
      end
    end
    #1;
    check("ack",         32'(ack),         m_write ? (32'd1 << m_grant) : 32'd0);
    check("wrn",         32'(wrn),         m_write ? 32'd0 : 32'd1);
    check("busy",        32'(busy),        32'(m_active));
    check("grant_id",    32'(grant_id),    32'(m_grant));
    check("d_in",        32'(d_in),        32'(m_data));
    check("frames_sent", 32'(frames_sent), 32'(m_frames));
    check("wdog_err",    32'(wdog_err),    32'(m_err));
  end

  // ---------------- transmitter model ----------------
  initial begin
    forever begin
      @(negedge clk_uart);
      if (tx_auto && wrn === 1'b0) begin
        @(negedge clk_uart);
        @(negedge clk_uart);
        sending = 1'b1; t_empty = 1'b0;
        repeat (12) @(negedge clk_uart);
        sending = 1'b0; t_empty = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk_uart);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  task automatic wait_ack(input string tag, output int idx);
    int n = 0;
    idx = -1;
    while (ack == '0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
    for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_idle_reached"}, 32'(busy), 32'd0);
  endtask

  int ord[4];
  int idx;
  int n_low;
  int n_wait;

  initial begin
    do_reset();

    // Single request: latency, one-cycle strobe, byte, ack, count.
    req_data = 32'h4433_22A5;
    req = 4'b0001;
    tick();
    check("single_wrn_low", 32'(wrn), 32'd0);
    check("single_ack", 32'(ack), 32'h1);
    check("single_d_in", 32'(d_in), 32'hA5);
    req = 4'b0000;
    n_low = 1;
    n_wait = 0;
    while (busy && n_wait < 300) begin
      tick();
      n_wait++;
      if (wrn == 1'b0) n_low++;
    end
    check("single_wrn_cycles", 32'(n_low), 32'd1);
    check("single_frames", 32'(frames_sent), 32'd1);

    // All channels requesting: round-robin order from reset.
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      wait_ack("all", idx);
      ord[f] = idx;
      if (f == 3) req = 4'b0000;
      tick();
    end
    wait_idle("all");
    for (int f = 0; f < 4; f++) check("all_order", 32'(ord[f]), 32'(f));
    check("all_frames", 32'(frames_sent), 32'd4);

    // Late request raised while channel 1 is mid-frame.
    do_reset();
    req = 4'b0010;
    wait_ack("late_first", idx);
    check("late_first_ch", 32'(idx), 32'd1);
    req = 4'b0000;
    repeat (5) tick();
    req = 4'b0100;
    n_wait = 0;
    while (busy && n_wait < 300) begin
      check("late_no_ack", 32'(ack), 32'd0);
      tick();
      n_wait++;
    end
    wait_ack("late_second", idx);
    check("late_second_ch", 32'(idx), 32'd2);
    check("late_grant_id", 32'(grant_id), 32'd2);
    req = 4'b0000;
    wait_idle("late");
    check("late_frames", 32'(frames_sent), 32'd2);

    // Reset in the middle of a frame.
    req = 4'b0001;
    wait_ack("midrst", idx);
    req = 4'b0000;
    repeat (5) tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    check("midrst_wrn", 32'(wrn), 32'd1);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    check("midrst_d_in", 32'(d_in), 32'd0);
    repeat (15) tick();
    check("midrst_frames_after", 32'(frames_sent), 32'd0);

    // Counter wrap from 0xFFFF.
    force dut.frames_sent = 16'hFFFF;
    preset_frames = 1'b1;
    tick();
    release dut.frames_sent;
    preset_frames = 1'b0;
    tick();
    check("wrap_preset", 32'(frames_sent), 32'hFFFF);
    req = 4'b0001;
    wait_ack("wrap", idx);
    req = 4'b0000;
    wait_idle("wrap");
    check("wrap_frames", 32'(frames_sent), 32'h0000);

    // Transmitter never starts after the write.
    do_reset();
    tx_auto = 1'b0;
    req = 4'b0001;
    wait_ack("wdog", idx);
    req = 4'b0000;
`ifdef UART_ARB_WDOG_EN
    n_wait = 0;
    tick();
    while (busy && n_wait < 100) begin
      n_wait++;
      tick();
    end
    check("wdog_wait_cycles", 32'(n_wait), 32'd32);
    check("wdog_err_set", 32'(wdog_err), 32'd1);
    check("wdog_frames", 32'(frames_sent), 32'd0);
`else
    repeat (40) tick();
    check("nowdog_still_busy", 32'(busy), 32'd1);
    check("nowdog_wrn", 32'(wrn), 32'd1);
    check("nowdog_err", 32'(wdog_err), 32'd0);
    sending = 1'b1;
    tick();
    sending = 1'b0;
    wait_idle("nowdog");
    check("nowdog_frames", 32'(frames_sent), 32'd1);
`endif
    tx_auto = 1'b1;
    do_reset();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
